// File: rtl/scpad_pkg.sv
// Shared sizing, state encoding and beat metadata for the scratchpad request arbiter.
// Optional beat-count burst cap in the arbiter is enabled with SCPAD_ARB_TIMEOUT_EN.
package scpad_pkg;

  localparam int unsigned NUM_SCPADS  = 3;
  localparam int unsigned DEF_NUM_REQ = 3;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned SEL_W = clog2_min1(NUM_SCPADS);
  localparam int unsigned SRC_W = clog2_min1(DEF_NUM_REQ);

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_t;

  // Routing metadata that travels with each forwarded beat
  typedef struct packed {
    logic [SRC_W-1:0] src;
    logic             last;
  } sp_meta_t;

endpackage

// File: rtl/scpad_rr_pick.sv
// Rotate-priority picker: first set request at or after ptr, searching cyclically.
module scpad_rr_pick #(
  parameter int unsigned N     = 3,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] pos;
  logic          found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = PW'((32'(ptr) + k) % N);
      if (!found && req[pos]) begin
        found    = 1'b1;
        gnt[pos] = 1'b1;
        idx      = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/scpad_arbiter.sv
// Burst-locked round-robin arbiter sharing NUM_SCPADS scratchpads between NUM_REQ requesters.
// Define SCPAD_ARB_TIMEOUT_EN to cap bursts at MAX_BEATS beats with a forced last.
module scpad_arbiter
  import scpad_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 3,
  parameter int unsigned REQ_W     = 64,
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*SEL_W-1:0]    req_sel,
  input  logic [NUM_REQ-1:0]          req_last,
  input  logic [NUM_REQ*REQ_W-1:0]    req_payload,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_SCPADS-1:0]       sp_valid,
  output logic [NUM_SCPADS*REQ_W-1:0] sp_payload,
  output logic [NUM_SCPADS*SRC_W-1:0] sp_src,
  output logic [NUM_SCPADS-1:0]       sp_last,
  input  logic [NUM_SCPADS-1:0]       sp_ready,
  output logic [NUM_SCPADS-1:0]       busy,
  output logic [NUM_SCPADS-1:0]       timeout_err
);

  if (NUM_REQ > (2 ** SRC_W)) begin : g_bad_num_req
    $error("scpad_arbiter: NUM_REQ does not fit in SRC_W");
  end
  if (MAX_BEATS == 0) begin : g_bad_max_beats
    $error("scpad_arbiter: MAX_BEATS must be at least 1");
  end

  arb_state_t       state_q   [NUM_SCPADS];
  arb_state_t       state_nxt [NUM_SCPADS];
  logic [SRC_W-1:0] owner_q   [NUM_SCPADS];
  logic [SRC_W-1:0] owner_nxt [NUM_SCPADS];
  logic [SRC_W-1:0] ptr_q     [NUM_SCPADS];
  logic [SRC_W-1:0] ptr_nxt   [NUM_SCPADS];

  logic [NUM_REQ-1:0] cand [NUM_SCPADS];
  logic [NUM_REQ-1:0] elig [NUM_SCPADS];
  logic [NUM_REQ-1:0] pick [NUM_SCPADS];
  logic [NUM_REQ-1:0] gnt  [NUM_SCPADS];
  logic [SRC_W-1:0]   win  [NUM_SCPADS];

  logic [NUM_SCPADS-1:0] slot_free;
  logic [NUM_SCPADS-1:0] accept;
  logic [NUM_SCPADS-1:0] load_last;
  logic                  held;

  logic [NUM_SCPADS-1:0] sp_valid_q;
  logic [REQ_W-1:0]      payload_q [NUM_SCPADS];
  sp_meta_t              meta_q    [NUM_SCPADS];

`ifdef SCPAD_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(MAX_BEATS + 1);
  logic [CNT_W-1:0]      cnt_q   [NUM_SCPADS];
  logic [CNT_W-1:0]      cnt_nxt [NUM_SCPADS];
  logic [NUM_SCPADS-1:0] force_last;
  logic [NUM_SCPADS-1:0] tout_q;
`endif

  // Candidates: valid, targeting s, and not holding a lock on another scratchpad
  always_comb begin
    held = 1'b0;
    for (int s = 0; s < int'(NUM_SCPADS); s++) begin
      cand[s] = '0;
      for (int r = 0; r < int'(NUM_REQ); r++) begin
        held = 1'b0;
        for (int s2 = 0; s2 < int'(NUM_SCPADS); s2++) begin
          if (s2 != s && state_q[s2] == ARB_LOCK && owner_q[s2] == SRC_W'(r)) held = 1'b1;
        end
        cand[s][r] = req_valid[r] && (req_sel[r*SEL_W +: SEL_W] == SEL_W'(s)) && !held;
      end
      elig[s] = (state_q[s] == ARB_LOCK) ? (cand[s] & (NUM_REQ'(1) << owner_q[s])) : cand[s];
    end
  end

  for (genvar s = 0; s < NUM_SCPADS; s++) begin : g_pick
    scpad_rr_pick #(
      .N     (NUM_REQ),
      .IDX_W (SRC_W)
    ) u_pick (
      .req (elig[s]),
      .ptr (ptr_q[s]),
      .gnt (pick[s]),
      .idx (win[s])
    );

    assign slot_free[s] = !sp_valid_q[s] || sp_ready[s];
    assign gnt[s]       = rst ? '0 : (pick[s] & {NUM_REQ{slot_free[s]}});
    assign accept[s]    = |gnt[s];
  end

  // A requester targets one scratchpad at a time, so at most one grant term is set
  always_comb begin
    req_ready = '0;
    for (int s = 0; s < int'(NUM_SCPADS); s++) begin
      req_ready = req_ready | gnt[s];
    end
  end

  // Lock FSM next state, owner, pointer and burst counter
  always_comb begin
    state_nxt = state_q;
    owner_nxt = owner_q;
    ptr_nxt   = ptr_q;
    load_last = '0;
`ifdef SCPAD_ARB_TIMEOUT_EN
    cnt_nxt    = cnt_q;
    force_last = '0;
`endif
    for (int s = 0; s < int'(NUM_SCPADS); s++) begin
      load_last[s] = req_last[win[s]];
      if (accept[s]) begin
`ifdef SCPAD_ARB_TIMEOUT_EN
        force_last[s] = !req_last[win[s]] && (cnt_q[s] == CNT_W'(MAX_BEATS - 1));
        load_last[s]  = req_last[win[s]] || force_last[s];
`endif
        if (load_last[s]) begin
          state_nxt[s] = ARB_IDLE;
          ptr_nxt[s]   = (win[s] == SRC_W'(NUM_REQ - 1)) ? '0 : (win[s] + SRC_W'(1));
`ifdef SCPAD_ARB_TIMEOUT_EN
          cnt_nxt[s]   = '0;
`endif
        end else begin
          state_nxt[s] = ARB_LOCK;
          owner_nxt[s] = win[s];
`ifdef SCPAD_ARB_TIMEOUT_EN
          cnt_nxt[s]   = cnt_q[s] + CNT_W'(1);
`endif
        end
      end
    end
  end

  // State registers and per-scratchpad one-entry output register
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_valid_q <= '0;
      for (int s = 0; s < int'(NUM_SCPADS); s++) begin
        state_q[s]   <= ARB_IDLE;
        owner_q[s]   <= '0;
        ptr_q[s]     <= '0;
        payload_q[s] <= '0;
        meta_q[s]    <= '0;
`ifdef SCPAD_ARB_TIMEOUT_EN
        cnt_q[s]     <= '0;
`endif
      end
`ifdef SCPAD_ARB_TIMEOUT_EN
      tout_q <= '0;
`endif
    end else begin
      for (int s = 0; s < int'(NUM_SCPADS); s++) begin
        state_q[s] <= state_nxt[s];
        owner_q[s] <= owner_nxt[s];
        ptr_q[s]   <= ptr_nxt[s];
`ifdef SCPAD_ARB_TIMEOUT_EN
        cnt_q[s]   <= cnt_nxt[s];
`endif
        if (accept[s]) begin
          sp_valid_q[s] <= 1'b1;
          payload_q[s]  <= req_payload[int'(win[s])*int'(REQ_W) +: REQ_W];
          meta_q[s]     <= '{src: win[s], last: load_last[s]};
        end else if (sp_ready[s]) begin
          sp_valid_q[s] <= 1'b0;
        end
      end
`ifdef SCPAD_ARB_TIMEOUT_EN
      tout_q <= force_last;
`endif
    end
  end

  for (genvar s = 0; s < NUM_SCPADS; s++) begin : g_out
    assign sp_payload[s*REQ_W +: REQ_W] = payload_q[s];
    assign sp_src[s*SRC_W +: SRC_W]     = meta_q[s].src;
    assign sp_last[s]                   = meta_q[s].last;
    assign busy[s]                      = (state_q[s] == ARB_LOCK);
  end
  assign sp_valid = sp_valid_q;

`ifdef SCPAD_ARB_TIMEOUT_EN
  assign timeout_err = tout_q;
`else
  assign timeout_err = '0;
`endif

  // Out-of-range scratchpad selects are never granted; flag them in simulation
  for (genvar r = 0; r < NUM_REQ; r++) begin : g_sel_chk
    a_sel_range: assert property (@(posedge clk) disable iff (rst)
      req_valid[r] |-> (int'(req_sel[r*SEL_W +: SEL_W]) < int'(NUM_SCPADS)));
  end

endmodule
